// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the data-memory responder and its word RAM.
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for a word array of the given depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous read port.
module dm_word_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [BE_W-1:0]               be,
  input  logic [idx_width(DEPTH)-1:0]   idx,
  input  logic [WORD_W-1:0]             wdata,
  output logic [WORD_W-1:0]             rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately left out of reset; only enabled bytes are touched.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: one outstanding load/store,
// fixed access latency, error reporting for misaligned or out-of-range addresses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int               IDX_W       = idx_width(DEPTH);
  localparam logic [29:0]      DEPTH_WORDS = 30'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 1);

  state_t state, state_next;

  logic              ready_en;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              accept;
  logic              execute;
  logic              misaligned;
  logic              out_of_range;
  logic              access_err;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] ram_rdata;

  // Misalignment is checked first; the index is only meaningful once the range check passes.
  always_comb begin
    accept       = req_valid & req_ready;
    execute      = (state == BUSY) && (cnt == '0);
    misaligned   = (lat_addr[1:0] != 2'b00);
    out_of_range = (lat_addr[31:2] >= DEPTH_WORDS);
    access_err   = misaligned | out_of_range;
    ram_idx      = lat_addr[IDX_W+1:2];
    ram_we       = execute & lat_write & ~access_err & ~reset;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ready_en;
        if (req_valid && ready_en) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ready_en keeps req_ready low until the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en   <= 1'b0;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= CNT_LOAD;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (execute) begin
        resp_rdata <= (lat_write || access_err) ? '0 : ram_rdata;
        resp_err   <= access_err;
      end else if ((state == RESP) && resp_ready) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  dm_word_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (lat_be),
    .idx  (ram_idx),
    .wdata(lat_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for function and
// error checks, and a LATENCY=1 instance for throughput timing.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid_l1, req_ready_l1, req_write_l1;
  logic [31:0] req_addr_l1, req_wdata_l1;
  logic [3:0]  req_be_l1;
  logic        resp_valid_l1, resp_ready_l1, resp_err_l1;
  logic [31:0] resp_rdata_l1;

  int compare_count  = 0;
  int mismatch_count = 0;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_l1), .req_ready(req_ready_l1), .req_write(req_write_l1),
    .req_addr(req_addr_l1), .req_wdata(req_wdata_l1), .req_be(req_be_l1),
    .resp_valid(resp_valid_l1), .resp_ready(resp_ready_l1),
    .resp_rdata(resp_rdata_l1), .resp_err(resp_err_l1)
  );

  // Edge-stamped handshake events on the LATENCY=1 instance.
  int cyc = 0;
  int acc_q[$];
  int rsp_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid_l1 && req_ready_l1) acc_q.push_back(cyc);
    if (resp_valid_l1 && resp_ready_l1) rsp_q.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one request, measures accept-to-resp_valid latency, then consumes the response.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] rdata,
                               output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) checkOutput("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    req_valid_l1 = 1'b0; req_write_l1 = 1'b0; req_addr_l1 = '0; req_wdata_l1 = '0; req_be_l1 = '0;
    resp_ready_l1 = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Store then load.
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checkOutput("st10_latency", 32'(lat), 32'd2);
    checkOutput("st10_err", 32'(er), 32'd0);
    checkOutput("st10_rdata", rd, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checkOutput("ld10_latency", 32'(lat), 32'd2);
    checkOutput("ld10_rdata", rd, 32'hDEADBEEF);
    checkOutput("ld10_err", 32'(er), 32'd0);

    // Byte enables: bytes 0 and 2 replaced.
    applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    checkOutput("st20_be_err", 32'(er), 32'd0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checkOutput("ld20_merged", rd, 32'h11BB33DD);

    // Errors and boundaries.
    applyStimulus(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    applyStimulus(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    checkOutput("ld22_err", 32'(er), 32'd1);
    checkOutput("ld22_rdata", rd, 32'd0);
    applyStimulus(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    checkOutput("st400_err", 32'(er), 32'd1);
    applyStimulus(1'b1, 32'h1, 32'h12345678, 4'hF, rd, er, lat);
    checkOutput("st01_err", 32'(er), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    checkOutput("ld00_unchanged", rd, 32'hCAFEF00D);
    checkOutput("ld00_err", 32'(er), 32'd0);
    applyStimulus(1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF, rd, er, lat);
    checkOutput("st3fc_err", 32'(er), 32'd0);
    applyStimulus(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    checkOutput("ld3fc_rdata", rd, 32'h0BADCAFE);
    applyStimulus(1'b1, 32'h80000010, 32'h77777777, 4'hF, rd, er, lat);
    checkOutput("st_high_err", 32'(er), 32'd1);
    applyStimulus(1'b1, 32'h10, 32'h99999999, 4'h0, rd, er, lat);
    checkOutput("st10_be0_err", 32'(er), 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checkOutput("ld10_after_noop", rd, 32'hDEADBEEF);

    // Backpressure with a second request waiting.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
    checkOutput("bp_first_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_addr = 32'h20;
    guard = 0;
    while (!resp_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("bp_resp_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
      checkOutput("bp_resp_err", 32'(resp_err), 32'd0);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("bp_released_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp_released_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    checkOutput("bp_second_taken", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("bp_second_timeout", 32'd0, 32'd1);
    checkOutput("bp_second_rdata", resp_rdata, 32'h11BB33DD);
    resp_ready = 1'b1;
    @(negedge clk);

    // resp_ready while idle has no effect.
    repeat (3) @(negedge clk);
    checkOutput("idle_rr_valid", 32'(resp_valid), 32'd0);
    checkOutput("idle_rr_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;

    // LATENCY=1 throughput with resp_ready tied high.
    @(negedge clk);
    req_valid_l1 = 1'b1;
    guard = 0;
    while (acc_q.size() < 3 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    req_valid_l1 = 1'b0;
    if (guard >= 40) checkOutput("l1_accept_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("l1_accepts", 32'(acc_q.size()), 32'd3);
    checkOutput("l1_resps", 32'(rsp_q.size()), 32'd3);
    if (acc_q.size() >= 3 && rsp_q.size() >= 3) begin
      checkOutput("l1_spacing_01", 32'(acc_q[1] - acc_q[0]), 32'd3);
      checkOutput("l1_spacing_12", 32'(acc_q[2] - acc_q[1]), 32'd3);
      for (int i = 0; i < 3; i++) begin
        checkOutput("l1_resp_edge", 32'(rsp_q[i] - acc_q[i]), 32'd2);
      end
    end

    // Reset on the execute edge of a store.
    applyStimulus(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55555555; req_be = 4'hF;
    checkOutput("rma_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rma_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rma_resp_valid", 32'(resp_valid), 32'd0);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    checkOutput("rma_ld30", rd, 32'h0);
    checkOutput("rma_ld30_err", 32'(er), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
